// File: rtl/pfsoc_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pfsoc_init_pkg
// Brief    : Shared types and width helpers for the init-done reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pfsoc_init_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_WAIT_DONE = 2'd0,
        ST_DELAY     = 2'd1,
        ST_RUN       = 2'd2,
        ST_ERROR     = 2'd3
    } state_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1)
    function automatic int CNT_W(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of a stage index for n stages (never narrower than 1)
    function automatic int IDX_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pfsoc_init_filter.sv
`default_nettype none
// ============================================================================
// Module   : pfsoc_init_filter
// Brief    : Two-flop synchroniser plus stability filter for one raw
//            init-done flag. The qualified flag rises after STABLE_CYCLES
//            consecutive synced highs and falls on the first synced low.
// Revision : 1.0 - initial release
// ============================================================================
module pfsoc_init_filter
    import pfsoc_init_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic done_o
);

    localparam int CTR_W = CNT_W(STABLE_CYCLES);
    localparam logic [CTR_W-1:0] CNT_LAST =
        (STABLE_CYCLES > 1) ? CTR_W'(STABLE_CYCLES - 1) : '0;

    logic             sync1_q;
    logic             sync2_q;
    logic             done_q;
    logic [CTR_W-1:0] cnt_q;

    // Bring the asynchronous flag into the clock domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive synced highs; counter parks at its last value once qualified
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (!sync2_q) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (cnt_q >= CNT_LAST) begin
            done_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/pfsoc_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pfsoc_init_sequencer
// Brief    : Qualifies N_CH init-done flags and releases per-stage fabric
//            resets strictly in index order, with per-stage timeout, drop
//            detection and RETRY-driven re-sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module pfsoc_init_sequencer
    import pfsoc_init_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int RELEASE_DELAY  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CH-1:0]         init_done_i,
    input  logic                    retry_i,
    output logic [N_CH-1:0]         reset_out_n_o,
    output logic                    all_done_o,
    output logic                    timeout_err_o,
    output logic                    drop_err_o,
    output logic [IDX_W(N_CH)-1:0]  err_stage_o,
    output logic [IDX_W(N_CH)-1:0]  cur_stage_o
);

    localparam int STG_W  = IDX_W(N_CH);
    localparam int TMO_W  = CNT_W(TIMEOUT_CYCLES);
    localparam int DLY_W  = CNT_W(RELEASE_DELAY);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
    // Release happens on the edge that would take dly_cnt to RELEASE_DELAY
    localparam logic [DLY_W-1:0] DLY_LAST =
        (RELEASE_DELAY > 0) ? DLY_W'(RELEASE_DELAY - 1) : '0;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N_CH - 1);

    logic [N_CH-1:0]  qual_done;
    logic [N_CH-1:0]  drop_vec;
    logic             drop_any;
    logic [STG_W-1:0] drop_idx;

    state_e           state_q,     state_d;
    logic [STG_W-1:0] cur_q,       cur_d;
    logic [STG_W-1:0] err_stage_q, err_stage_d;
    logic [TMO_W-1:0] tmo_q,       tmo_d;
    logic [DLY_W-1:0] dly_q,       dly_d;
    logic [N_CH-1:0]  rst_n_q,     rst_n_d;
    logic             all_done_q,  all_done_d;
    logic             tmo_err_q,   tmo_err_d;
    logic             drop_err_q,  drop_err_d;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_filter
            pfsoc_init_filter #(
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_filter (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .raw_i  (init_done_i[g]),
                .done_o (qual_done[g])
            );
        end
    endgenerate

    // Released stages whose qualified done has fallen; the lowest index is reported
    always_comb begin
        drop_vec = rst_n_q & ~qual_done;
        drop_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (drop_vec[k]) begin
                drop_idx = STG_W'(k);
            end
        end
    end

    assign drop_any = |drop_vec;

    // Next-state logic; a drop outranks every other event outside ERROR
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        err_stage_d = err_stage_q;
        tmo_d       = tmo_q;
        dly_d       = dly_q;
        rst_n_d     = rst_n_q;
        all_done_d  = all_done_q;
        tmo_err_d   = tmo_err_q;
        drop_err_d  = drop_err_q;

        if (state_q != ST_ERROR && drop_any) begin
            state_d     = ST_ERROR;
            drop_err_d  = 1'b1;
            err_stage_d = drop_idx;
            rst_n_d     = '0;
            all_done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_DONE: begin
                    if (tmo_q != '1) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                    if (qual_done[cur_q]) begin
                        state_d = ST_DELAY;
                        dly_d   = '0;
                    end else if (TMO_EN && tmo_q == TMO_LAST) begin
                        state_d     = ST_ERROR;
                        tmo_err_d   = 1'b1;
                        err_stage_d = cur_q;
                        rst_n_d     = '0;
                        all_done_d  = 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (!qual_done[cur_q]) begin
                        // Stage lost its done before release: wait again, timeout keeps running
                        state_d = ST_WAIT_DONE;
                    end else if (dly_q >= DLY_LAST) begin
                        rst_n_d[cur_q] = 1'b1;
                        if (cur_q == LAST_STAGE) begin
                            state_d    = ST_RUN;
                            all_done_d = 1'b1;
                        end else begin
                            cur_d   = cur_q + 1'b1;
                            tmo_d   = '0;
                            state_d = ST_WAIT_DONE;
                        end
                    end else if (dly_q != '1) begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                ST_ERROR: begin
                    if (retry_i) begin
                        state_d     = ST_WAIT_DONE;
                        tmo_err_d   = 1'b0;
                        drop_err_d  = 1'b0;
                        err_stage_d = '0;
                        cur_d       = '0;
                        tmo_d       = '0;
                        dly_d       = '0;
                    end
                end
                default: begin
                    state_d = ST_WAIT_DONE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset returns everything to idle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_WAIT_DONE;
            cur_q       <= '0;
            err_stage_q <= '0;
            tmo_q       <= '0;
            dly_q       <= '0;
            rst_n_q     <= '0;
            all_done_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            err_stage_q <= err_stage_d;
            tmo_q       <= tmo_d;
            dly_q       <= dly_d;
            rst_n_q     <= rst_n_d;
            all_done_q  <= all_done_d;
            tmo_err_q   <= tmo_err_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign reset_out_n_o = rst_n_q;
    assign all_done_o    = all_done_q;
    assign timeout_err_o = tmo_err_q;
    assign drop_err_o    = drop_err_q;
    assign err_stage_o   = err_stage_q;
    assign cur_stage_o   = cur_q;

endmodule
`default_nettype wire
